// File: rtl/weight_updater.sv
// Weight store and update engine: NW signed Q6.10 weights, one delta applied per weight per epoch.
// Optional macro WU_SATURATE_EN clamps the update result; without it the 17-bit difference wraps to 16 bits.
module weight_updater #(
    parameter int NW       = 8,
    parameter int AW       = 3,
    parameter int LR_SHIFT = 3
) (
    input  logic          clk,
    input  logic          res,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [15:0]   load_data,
    input  logic          start,
    input  logic          delta_valid,
    output logic          delta_ready,
    input  logic [15:0]   delta,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          busy,
    output logic          epoch_done,
    output logic [15:0]   epoch_count
);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          epoch_done_q, epoch_done_d;
    logic [15:0]   epoch_count_q, epoch_count_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [15:0]   w_q [NW];
    logic [15:0]   w_d [NW];

    logic               load_fire, delta_fire;
    logic signed [15:0] delta_sh;
    logic [15:0]        w_cur, w_upd;
    logic [16:0]        diff;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            epoch_done_q  <= 1'b0;
            epoch_count_q <= '0;
            load_ptr_q    <= '0;
            idx_q         <= '0;
            rd_data_q     <= '0;
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            epoch_done_q  <= epoch_done_d;
            epoch_count_q <= epoch_count_d;
            load_ptr_q    <= load_ptr_d;
            idx_q         <= idx_d;
            rd_data_q     <= rd_data_d;
            w_q           <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = UPDATE;
            UPDATE:  if (delta_valid && idx_q == AW'(NW - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // 17-bit difference keeps the overflow bit so saturation can see it
    always_comb begin
        delta_sh = $signed(delta) >>> LR_SHIFT;
        w_cur    = w_q[idx_q];
        diff     = {w_cur[15], w_cur} - {delta_sh[15], delta_sh};
`ifdef WU_SATURATE_EN
        if (diff[16] != diff[15]) w_upd = diff[16] ? 16'h8000 : 16'h7FFF;
        else                      w_upd = diff[15:0];
`else
        w_upd = diff[15:0];
`endif
    end

    always_comb begin
        load_ready    = (state_q == IDLE);
        delta_ready   = (state_q == UPDATE);
        load_fire     = load_valid && load_ready;
        delta_fire    = delta_valid && delta_ready;
        w_d           = w_q;
        load_ptr_d    = load_ptr_q;
        idx_d         = idx_q;
        epoch_count_d = epoch_count_q;
        if (load_fire) begin
            w_d[load_ptr_q] = load_data;
            load_ptr_d = (load_ptr_q == AW'(NW - 1)) ? '0 : load_ptr_q + 1'b1;
        end
        if (state_q == IDLE && start) idx_d = '0;
        if (delta_fire) begin
            w_d[idx_q] = w_upd;
            idx_d      = idx_q + 1'b1;
        end
        if (state_q == DONE) begin
            epoch_count_d = epoch_count_q + 16'd1;
            load_ptr_d    = '0;
        end
        busy_d       = (state_d != IDLE);
        epoch_done_d = (state_d == DONE);
        rd_data_d    = w_q[rd_addr];
    end

    assign rd_data     = rd_data_q;
    assign busy        = busy_q;
    assign epoch_done  = epoch_done_q;
    assign epoch_count = epoch_count_q;

endmodule

// File: tb/tb_weight_updater.sv
// Directed bench for weight_updater: bench-side weight model feeds an expected-value queue
// that is popped and compared as registered read data comes back.
module tb_weight_updater;

    localparam int NW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          res;
    logic          load_valid;
    logic          load_ready;
    logic [15:0]   load_data;
    logic          start;
    logic          delta_valid;
    logic          delta_ready;
    logic [15:0]   delta;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          busy;
    logic          epoch_done;
    logic [15:0]   epoch_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] model [NW];
    logic [15:0] exp_q [$];

    weight_updater #(.NW(NW), .AW(AW), .LR_SHIFT(3)) dut (
        .clk(clk), .res(res),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .start(start),
        .delta_valid(delta_valid), .delta_ready(delta_ready), .delta(delta),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .epoch_done(epoch_done), .epoch_count(epoch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference update: w - floor(delta / 8), clamped or wrapped to 16 bits
    function automatic logic [15:0] upd(input logic [15:0] w, input logic [15:0] d);
        int dv, wv, r;
        dv = int'($signed(d));
        wv = int'($signed(w));
        r  = wv - (dv >>> 3);
`ifdef WU_SATURATE_EN
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic read_chk(input int a, input string tag);
        logic [15:0] got;
        exp_q.push_back(model[a]);
        rd_addr = AW'(a);
        tick();
        got = exp_q.pop_front();
        chk($sformatf("%s[%0d]", tag, a), {16'h0, rd_data}, {16'h0, got});
    endtask

    logic [15:0] ld1 [NW] = '{16'h0400, 16'h8010, 16'h0000, 16'h7FF0,
                              16'h1234, 16'hFF00, 16'h8000, 16'h0001};
    logic [15:0] dl1 [NW] = '{16'h0800, 16'h7FFF, 16'hF800, 16'h8000,
                              16'h0010, 16'h0007, 16'h0008, 16'hFFFF};

    initial begin
        int xfers, done_cnt, done_cyc, last_cyc;
        logic hs;
        logic [15:0] old;
        res = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
        delta_valid = 1'b0; delta = '0; rd_addr = '0;
        for (int i = 0; i < NW; i++) model[i] = '0;
        tick(); tick();
        res = 1'b0;

        chk("rst_load_ready", {31'h0, load_ready}, 32'h1);
        chk("rst_delta_ready", {31'h0, delta_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_epoch_done", {31'h0, epoch_done}, 32'h0);
        chk("rst_epoch_count", {16'h0, epoch_count}, 32'h0);
        for (int i = 0; i < NW; i++) read_chk(i, "rst_rd");

        // Load all weights; the last load shares its cycle with start
        for (int i = 0; i < NW; i++) begin
            load_valid = 1'b1;
            load_data  = ld1[i];
            start      = (i == NW - 1);
            chk("load_ready_idle", {31'h0, load_ready}, 32'h1);
            tick();
            model[i] = ld1[i];
        end
        load_valid = 1'b0; start = 1'b0;
        chk("start_delta_ready", {31'h0, delta_ready}, 32'h1);
        chk("start_busy", {31'h0, busy}, 32'h1);

        // Epoch with toggling valid; stray start mid-epoch; read the address being written
        xfers = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            delta_valid = (cyc % 2 == 0);
            delta       = (xfers < NW) ? dl1[xfers] : 16'h0;
            start       = (cyc == 5);
            rd_addr     = AW'(xfers % NW);
            hs          = delta_valid && delta_ready;
            old         = model[xfers % NW];
            if (hs) exp_q.push_back(old);
            tick();
            if (hs) begin
                chk($sformatf("rdw_old[%0d]", xfers), {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
                model[xfers] = upd(old, dl1[xfers]);
                xfers++;
                last_cyc = cyc;
            end
            if (epoch_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        delta_valid = 1'b0; start = 1'b0;
        chk("xfer_count", xfers, NW);
        chk("done_pulses", done_cnt, 1);
        chk("done_timing", done_cyc, last_cyc);
        chk("epoch_count_1", {16'h0, epoch_count}, 32'h1);
        chk("idle_load_ready", {31'h0, load_ready}, 32'h1);
        chk("idle_busy", {31'h0, busy}, 32'h0);
        for (int i = 0; i < NW; i++) read_chk(i, "ep1_rd");

        // Abort: three deltas then reset
        for (int i = 0; i < NW; i++) begin
            load_valid = 1'b1;
            load_data  = 16'(16'h0101 * (i + 1));
            tick();
            model[i] = load_data;
        end
        load_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            delta_valid = 1'b1;
            delta = 16'h0040;
            tick();
            if (epoch_done) done_cnt++;
        end
        delta_valid = 1'b0;
        res = 1'b1;
        tick();
        if (epoch_done) done_cnt++;
        res = 1'b0;
        chk("abort_delta_ready", {31'h0, delta_ready}, 32'h0);
        chk("abort_load_ready", {31'h0, load_ready}, 32'h1);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_epoch_count", {16'h0, epoch_count}, 32'h0);
        for (int i = 0; i < NW; i++) model[i] = '0;
        for (int i = 0; i < NW; i++) begin
            read_chk(i, "abort_rd");
            if (epoch_done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
